// File: rtl/tpu_pkg.sv
// Shared TPU constants, accumulator sizing and MAC responder state encoding.
package tpu_pkg;

  localparam int unsigned TPU_DW    = 16;
  localparam int unsigned TPU_LANES = 128;
  localparam int unsigned TPU_LPC   = 8;

  // Width that holds any full LANES-term dot product of DW-bit signed operands.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned lanes);
    return 2*dw + $clog2(lanes);
  endfunction

  localparam int unsigned TPU_ACC_W = acc_width(TPU_DW, TPU_LANES);
  localparam int unsigned TPU_RES_W = 2*TPU_DW - 1;

  localparam logic signed [TPU_ACC_W-1:0] SAT_MAX =
    {{(TPU_ACC_W-TPU_RES_W+1){1'b0}}, {(TPU_RES_W-1){1'b1}}};
  localparam logic signed [TPU_ACC_W-1:0] SAT_MIN =
    {{(TPU_ACC_W-TPU_RES_W+1){1'b1}}, {(TPU_RES_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } tpu_state_e;

endpackage

// File: rtl/tpu_mac_slice.sv
// Combinational LPC-lane signed multiply with a summing tree.
module tpu_mac_slice
  import tpu_pkg::*;
#(
  parameter int unsigned DW  = TPU_DW,
  parameter int unsigned LPC = TPU_LPC,
  parameter int unsigned SW  = 2*DW + $clog2(LPC)
) (
  input  logic [LPC*DW-1:0]    a,
  input  logic [LPC*DW-1:0]    b,
  output logic signed [SW-1:0] sum_c
);

  localparam int unsigned PW = 2*DW;

  always_comb begin
    logic signed [DW-1:0] a_l;
    logic signed [DW-1:0] b_l;
    logic signed [PW-1:0] prod;
    a_l   = '0;
    b_l   = '0;
    prod  = '0;
    sum_c = '0;
    for (int j = 0; j < int'(LPC); j++) begin
      a_l   = a[j*DW +: DW];
      b_l   = b[j*DW +: DW];
      prod  = PW'(a_l) * PW'(b_l);
      sum_c = sum_c + SW'(prod);
    end
  end

endmodule

// File: rtl/tpu_mac_responder.sv
// Time-multiplexed 128-lane dot-product responder with saturated 31-bit result.
module tpu_mac_responder
  import tpu_pkg::*;
#(
  parameter int unsigned LANES = TPU_LANES,
  parameter int unsigned DW    = TPU_DW,
  parameter int unsigned LPC   = TPU_LPC
) (
  input  logic                clk,
  input  logic                iRst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [LANES*DW-1:0] req_opr1,
  input  logic [LANES*DW-1:0] req_opr2,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [2*DW-2:0]     resp_data,
  output logic                resp_overflow,
  output logic                busy
);

  localparam int unsigned VW    = LANES*DW;
  localparam int unsigned WIN_W = LPC*DW;
  localparam int unsigned SW    = 2*DW + $clog2(LPC);
  localparam int unsigned BEATS = LANES / LPC;
  localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned ACC_W = acc_width(DW, LANES);
  localparam int unsigned RES_W = 2*DW - 1;

  localparam logic signed [ACC_W-1:0] LIM_MAX =
    {{(ACC_W-RES_W+1){1'b0}}, {(RES_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] LIM_MIN =
    {{(ACC_W-RES_W+1){1'b1}}, {(RES_W-1){1'b0}}};

  tpu_state_e              state_q, state_d;
  logic [VW-1:0]           op1_q, op1_d;
  logic [VW-1:0]           op2_q, op2_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [BW-1:0]           beat_q, beat_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [RES_W-1:0]        resp_data_q, resp_data_d;
  logic                    resp_ovf_q, resp_ovf_d;

  logic signed [SW-1:0]    slice_sum;
  logic signed [ACC_W-1:0] final_sum;
  logic signed [ACC_W-1:0] sat_sum;
  logic                    sat_hit;
  logic                    last_beat;

  // Operand registers shift down one window per beat, so lane window is always the low bits.
  tpu_mac_slice #(.DW(DW), .LPC(LPC), .SW(SW)) u_slice (
    .a     (op1_q[WIN_W-1:0]),
    .b     (op2_q[WIN_W-1:0]),
    .sum_c (slice_sum)
  );

  assign last_beat = (beat_q == BW'(BEATS-1));
  assign final_sum = acc_q + ACC_W'(slice_sum);

  always_comb begin
    sat_sum = final_sum;
    sat_hit = 1'b0;
    if (final_sum > LIM_MAX) begin
      sat_sum = LIM_MAX;
      sat_hit = 1'b1;
    end else if (final_sum < LIM_MIN) begin
      sat_sum = LIM_MIN;
      sat_hit = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (iRst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid)  state_d = ACCUM;
      ACCUM:   if (last_beat)  state_d = DONE;
      DONE:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and response register updates
  always_comb begin
    op1_d        = op1_q;
    op2_d        = op2_q;
    acc_d        = acc_q;
    beat_d       = beat_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_ovf_d   = resp_ovf_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          op1_d  = req_opr1;
          op2_d  = req_opr2;
          acc_d  = '0;
          beat_d = '0;
        end
      end
      ACCUM: begin
        op1_d  = op1_q >> WIN_W;
        op2_d  = op2_q >> WIN_W;
        acc_d  = final_sum;
        beat_d = beat_q + BW'(1);
        if (last_beat) begin
          resp_valid_d = 1'b1;
          resp_data_d  = sat_sum[RES_W-1:0];
          resp_ovf_d   = sat_hit;
        end
      end
      DONE: begin
        if (resp_ready) resp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (iRst) begin
      op1_q        <= '0;
      op2_q        <= '0;
      acc_q        <= '0;
      beat_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_ovf_q   <= 1'b0;
    end else begin
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      acc_q        <= acc_d;
      beat_q       <= beat_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_ovf_q   <= resp_ovf_d;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign resp_valid    = resp_valid_q;
  assign resp_data     = resp_data_q;
  assign resp_overflow = resp_ovf_q;

endmodule

// File: tb/tb_tpu_mac_responder.sv
// Directed-vector bench for tpu_mac_responder with hand-computed dot products.
module tb_tpu_mac_responder;

  localparam int unsigned LANES = 128;
  localparam int unsigned DW    = 16;
  localparam int unsigned VW    = LANES*DW;

  logic          clk;
  logic          iRst;
  logic          req_valid;
  logic          req_ready;
  logic [VW-1:0] req_opr1;
  logic [VW-1:0] req_opr2;
  logic          resp_valid;
  logic          resp_ready;
  logic [30:0]   resp_data;
  logic          resp_overflow;
  logic          busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  tpu_mac_responder dut (
    .clk           (clk),
    .iRst          (iRst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_opr1      (req_opr1),
    .req_opr2      (req_opr2),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .resp_overflow (resp_overflow),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present a request and return just after its accept edge.
  task automatic issue(input logic [VW-1:0] a, input logic [VW-1:0] b);
    int n;
    @(negedge clk);
    req_opr1  = a;
    req_opr2  = b;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Count edges from the accept edge until resp_valid rises (bounded).
  task automatic wait_resp(output int lat);
    lat = 0;
    while (!resp_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    iRst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_opr1 = '0; req_opr2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    iRst = 1'b0;
    @(negedge clk);
    vec_cnt++; if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
    vec_cnt++; if (resp_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vec_cnt++; if (resp_data !== 31'd0) begin err_cnt++; $display("FAIL reset_resp_data: got %h expected 0", resp_data); end
    vec_cnt++; if (resp_overflow !== 1'b0) begin err_cnt++; $display("FAIL reset_overflow: got %b expected 0", resp_overflow); end
  endtask

  task automatic test_idle_resp_ready();
    @(negedge clk);
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    resp_ready = 1'b0;
    vec_cnt++; if (resp_valid !== 1'b0) begin err_cnt++; $display("FAIL idle_resp_ready_valid: got %b expected 0", resp_valid); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL idle_resp_ready_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    int lat;
    issue({LANES{16'h0400}}, {LANES{16'h0200}});
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL basic_busy: got %b expected 1", busy); end
    wait_resp(lat);
    vec_cnt++; if (lat != 16) begin err_cnt++; $display("FAIL basic_latency: got %0d expected 16", lat); end
    vec_cnt++; if (resp_data !== 31'd67108864) begin err_cnt++; $display("FAIL basic_data: got %h expected 4000000", resp_data); end
    vec_cnt++; if (resp_overflow !== 1'b0) begin err_cnt++; $display("FAIL basic_overflow: got %b expected 0", resp_overflow); end
    consume();
    vec_cnt++; if (resp_valid !== 1'b0) begin err_cnt++; $display("FAIL basic_handoff_valid: got %b expected 0", resp_valid); end
    vec_cnt++; if (resp_data !== 31'd67108864) begin err_cnt++; $display("FAIL basic_data_kept: got %h expected 4000000", resp_data); end
    vec_cnt++; if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL basic_back_idle: got %b expected 1", req_ready); end
  endtask

  task automatic test_sat_pos();
    int lat;
    issue({LANES{16'h7FFF}}, {LANES{16'h7FFF}});
    wait_resp(lat);
    vec_cnt++; if (lat != 16) begin err_cnt++; $display("FAIL sat_pos_latency: got %0d expected 16", lat); end
    vec_cnt++; if (resp_data !== 31'h3FFFFFFF) begin err_cnt++; $display("FAIL sat_pos_data: got %h expected 3fffffff", resp_data); end
    vec_cnt++; if (resp_overflow !== 1'b1) begin err_cnt++; $display("FAIL sat_pos_overflow: got %b expected 1", resp_overflow); end
    consume();
  endtask

  task automatic test_sat_neg();
    int lat;
    issue({LANES{16'h8000}}, {LANES{16'h7FFF}});
    wait_resp(lat);
    vec_cnt++; if (lat != 16) begin err_cnt++; $display("FAIL sat_neg_latency: got %0d expected 16", lat); end
    vec_cnt++; if (resp_data !== 31'h40000000) begin err_cnt++; $display("FAIL sat_neg_data: got %h expected 40000000", resp_data); end
    vec_cnt++; if (resp_overflow !== 1'b1) begin err_cnt++; $display("FAIL sat_neg_overflow: got %b expected 1", resp_overflow); end
    consume();
  endtask

  task automatic test_no_false_sat();
    int lat;
    logic [VW-1:0] a;
    logic [VW-1:0] b;
    a = '0; b = '0;
    a[15:0] = 16'h7FFF; a[31:16] = 16'h8000;
    b[15:0] = 16'h7FFF; b[31:16] = 16'h7FFF;
    issue(a, b);
    wait_resp(lat);
    vec_cnt++; if (lat != 16) begin err_cnt++; $display("FAIL mixed_latency: got %0d expected 16", lat); end
    vec_cnt++; if (resp_data !== 31'h7FFF8001) begin err_cnt++; $display("FAIL mixed_data: got %h expected 7fff8001", resp_data); end
    vec_cnt++; if (resp_overflow !== 1'b0) begin err_cnt++; $display("FAIL mixed_overflow: got %b expected 0", resp_overflow); end
    consume();
  endtask

  task automatic test_back_to_back();
    int lat;
    issue({LANES{16'h0400}}, {LANES{16'h0200}});
    wait_resp(lat);
    vec_cnt++; if (lat != 16) begin err_cnt++; $display("FAIL b2b_latency1: got %0d expected 16", lat); end
    @(negedge clk);
    req_opr1  = {LANES{16'h7FFF}};
    req_opr2  = {LANES{16'h0001}};
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      vec_cnt++; if (resp_valid !== 1'b1) begin err_cnt++; $display("FAIL b2b_hold_valid[%0d]: got %b expected 1", i, resp_valid); end
      vec_cnt++; if (resp_data !== 31'd67108864) begin err_cnt++; $display("FAIL b2b_hold_data[%0d]: got %h expected 4000000", i, resp_data); end
      vec_cnt++; if (req_ready !== 1'b0) begin err_cnt++; $display("FAIL b2b_hold_ready[%0d]: got %b expected 0", i, req_ready); end
    end
    consume();
    vec_cnt++; if (resp_valid !== 1'b0) begin err_cnt++; $display("FAIL b2b_handoff_valid: got %b expected 0", resp_valid); end
    vec_cnt++; if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL b2b_not_yet_accepted: got %b expected 1", req_ready); end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL b2b_accepted: got %b expected 1", busy); end
    wait_resp(lat);
    vec_cnt++; if (lat != 16) begin err_cnt++; $display("FAIL b2b_latency2: got %0d expected 16", lat); end
    vec_cnt++; if (resp_data !== 31'd4194176) begin err_cnt++; $display("FAIL b2b_data2: got %h expected 3fff80", resp_data); end
    vec_cnt++; if (resp_overflow !== 1'b0) begin err_cnt++; $display("FAIL b2b_overflow2: got %b expected 0", resp_overflow); end
    consume();
  endtask

  task automatic test_reset_mid();
    int lat;
    bit seen;
    issue({LANES{16'h7FFF}}, {LANES{16'h7FFF}});
    repeat (7) @(posedge clk);
    @(negedge clk);
    iRst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iRst = 1'b0;
    vec_cnt++; if (req_ready !== 1'b1) begin err_cnt++; $display("FAIL midrst_req_ready: got %b expected 1", req_ready); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    vec_cnt++; if (resp_data !== 31'd0) begin err_cnt++; $display("FAIL midrst_data: got %h expected 0", resp_data); end
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (resp_valid) seen = 1'b1;
    end
    vec_cnt++; if (seen !== 1'b0) begin err_cnt++; $display("FAIL midrst_no_resp: got %b expected 0", seen); end
    issue({LANES{16'h0400}}, {LANES{16'h0200}});
    wait_resp(lat);
    vec_cnt++; if (lat != 16) begin err_cnt++; $display("FAIL midrst_latency: got %0d expected 16", lat); end
    vec_cnt++; if (resp_data !== 31'd67108864) begin err_cnt++; $display("FAIL midrst_data_after: got %h expected 4000000", resp_data); end
    vec_cnt++; if (resp_overflow !== 1'b0) begin err_cnt++; $display("FAIL midrst_overflow_after: got %b expected 0", resp_overflow); end
    consume();
  endtask

  initial begin
    iRst = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_opr1 = '0; req_opr2 = '0;
    test_reset();
    test_idle_resp_ready();
    test_basic();
    test_sat_pos();
    test_sat_neg();
    test_no_false_sat();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/tpu_mac_responder.md
Name: tpu_mac_responder

Overview:
- Sequential multiply-accumulate responder serving the layer controllers (full_connect1/2) in the TPU.
- Accepts one 128-lane pair of 16-bit signed operand vectors per request and computes their dot product, LPC lanes per cycle.
- Returns a 31-bit signed result, saturated, with an overflow flag.
- Valid/ready handshakes on both sides let controllers trade the combinational multiply-add array for an area-lean time-multiplexed MAC.

Parameters:
- LANES, 128: lanes per operand vector.
- DW, 16: bits per lane, signed two's complement.
- LPC, 8: lanes processed per cycle; must divide LANES.
- ACC_W, 2*DW+$clog2(LANES): internal accumulator width (39 at defaults).

Ports:
- clk  in  1  system clock, rising edge.
- iRst  in  1  synchronous, active-high reset.
- req_valid  in  1  requester presents operands.
- req_ready  out  1  block can accept a request.
- req_opr1  in  LANES*DW  operand vector 1; lane i at bits [i*DW +: DW].
- req_opr2  in  LANES*DW  operand vector 2; same packing.
- resp_valid  out  1  result available.
- resp_ready  in  1  requester consumes result.
- resp_data  out  2*DW-1  saturated signed dot product.
- resp_overflow  out  1  saturation occurred for this result.
- busy  out  1  high in ACCUM or DONE.

Behaviour:
- One clock, synchronous active-high reset on iRst. Every flop is set by its reset value on a clock edge where iRst=1.
- Reset values:
  - state=IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_overflow=0, busy=0.
  - Accumulator and beat counter = 0.
- States: IDLE, ACCUM, DONE.
- req_ready = (state==IDLE), driven combinationally from state.
- busy = (state!=IDLE), driven combinationally from state.
- IDLE:
  - On an edge with req_valid && req_ready: latch req_opr1/req_opr2 into internal registers, clear accumulator, set beat=0, go to ACCUM.
  - Operands are sampled only on the accept edge. Later input changes are ignored.
- ACCUM, each edge:
  - acc += sum over lanes j = beat*LPC .. beat*LPC+LPC-1 of sext(op1[j]) * sext(op2[j]).
  - Each product is a full 2*DW-bit signed value. All sums are done at ACC_W, so the accumulator never wraps.
  - beat increments each edge.
- Final beat (beat==LANES/LPC-1):
  - Form final = acc + last partial sum.
  - Saturate final to 2*DW-1 bits signed: range -2^(2*DW-2) .. 2^(2*DW-2)-1 (±2^30 at defaults).
  - If clipped, resp_overflow=1, else 0.
  - Load resp_data, set resp_valid=1, go to DONE.
- Latency: resp_valid rises LANES/LPC edges after the accept edge (16 cycles at defaults).
- DONE:
  - resp_data, resp_overflow and resp_valid hold stable until an edge with resp_ready=1.
  - On that edge: resp_valid=0, go to IDLE.
  - resp_data and resp_overflow keep their last value after handoff.
- Back-to-back: req_ready is low in DONE, so a new request is accepted no earlier than the edge after the response handoff. Minimum issue interval is LANES/LPC+2 cycles.
- resp_ready asserted while resp_valid=0 has no effect.
- req_valid while busy is ignored. The requester must hold it until req_ready.
- Reset mid-operation, in ACCUM or DONE: the in-flight computation is discarded, no response is produced, and the block returns to IDLE with reset values on the next edge.
- Overflow is judged only on the final sum. Intermediate excursions never set the flag because the accumulator is ACC_W wide.

Decomposition:
- Shared package tpu_pkg holds:
  - TPU_DW=16, TPU_LANES=128, TPU_LPC=8.
  - ACC_W derivation.
  - Saturation limit constants SAT_MAX/SAT_MIN for 2*DW-1 bits.
  - State enum {IDLE, ACCUM, DONE}.
- One sub-module: tpu_mac_slice.
  - Combinational LPC-lane signed multiply and adder tree.
  - Output width 2*DW+$clog2(LPC).
  - Instantiated once and fed the beat-selected lane window.

Test Plan:
- Reset: hold iRst=1 for 3 cycles, then release. Check req_ready=1, resp_valid=0, busy=0, resp_data=0.
- All lanes op1=0x0400, op2=0x0200: resp_valid exactly 16 cycles after accept, resp_data=0x4000000 (67108864), resp_overflow=0.
- All lanes 0x7FFF×0x7FFF: resp_data=0x3FFFFFFF, resp_overflow=1.
- All lanes op1=0x8000, op2=0x7FFF: resp_data=31'h40000000 (-2^30), resp_overflow=1.
- Lane0 0x7FFF×0x7FFF, lane1 0x8000×0x7FFF, rest zero: resp_data=31'h7FFF8001 (-32767), resp_overflow=0, so there is no false saturation.
- Hold resp_ready=0 for 5 cycles: resp_data stays stable. A second request offered during DONE is not accepted until the edge after handoff.
- Assert iRst at beat 7 of a computation: no resp_valid pulse, then the next request completes correctly.
